seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_step.sv | 20 ++
 rtl/seq_multiplier.sv | 96 +++++++++
 tb/tb_seq_multiplier.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding and the step-counter width function.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: conditionally add or subtract the shifted partial.
// Purely combinational; all state lives in the parent.
module mul_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_partial,
    input  logic         i_bit,
    input  logic         i_sub,
    output logic [W-1:0] o_acc
);

    always_comb begin
        o_acc = i_acc;
        if (i_bit) begin
            o_acc = i_sub ? (i_acc - i_partial) : (i_acc + i_partial);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier, one multiplier bit per clock.
// Result is registered and only updated on the done edge.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic            r_sgn;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_result;
    logic            r_done;

    logic [PW-1:0]   w_a_ext;
    logic [PW-1:0]   w_partial;
    logic [PW-1:0]   w_acc_nxt;
    logic            w_bit;
    logic            w_last;
    logic            w_sub;

    assign w_a_ext   = {{WIDTH{r_sgn & r_a[WIDTH-1]}}, r_a};
    assign w_partial = w_a_ext << r_cnt;
    assign w_bit     = r_b[r_cnt];
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // The multiplier's sign bit carries weight -2^(WIDTH-1) in signed mode.
    assign w_sub     = r_sgn & w_last;

    mul_step #(
        .W (PW)
    ) u_step (
        .i_acc     (r_acc),
        .i_partial (w_partial),
        .i_bit     (w_bit),
        .i_sub     (w_sub),
        .o_acc     (w_acc_nxt)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sgn   <= signed_mode;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready  = (r_state == IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Expected products come from an integer reference multiply.
module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       arst;

    logic       s4, m4, rdy4, dn4;
    logic [3:0] a4, b4;
    logic [7:0] res4;

    logic        s8, m8, rdy8, dn8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) u4 (
        .clk         (clk),
        .arst        (arst),
        .start       (s4),
        .a           (a4),
        .b           (b4),
        .signed_mode (m4),
        .ready       (rdy4),
        .done        (dn4),
        .result      (res4)
    );

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk         (clk),
        .arst        (arst),
        .start       (s8),
        .a           (a8),
        .b           (b8),
        .signed_mode (m8),
        .ready       (rdy8),
        .done        (dn8),
        .result      (res8)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit m);
        longint sa, sb, p, mask;
        sa = longint'(a);
        sb = longint'(b);
        if (m && a[w-1]) sa = sa - (longint'(1) << w);
        if (m && b[w-1]) sb = sb - (longint'(1) << w);
        p    = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(p & mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit m,
                        output logic [7:0] r, output int lat);
        a4 = a; b4 = b; m4 = m; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (dn4) begin
                lat = i;
                break;
            end
        end
        r = res4;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit m,
                        output logic [15:0] r, output int lat);
        a8 = a; b8 = b; m8 = m; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (dn8) begin
                lat = i;
                break;
            end
        end
        r = res8;
    endtask

    initial begin
        logic [7:0]  r4;
        logic [15:0] r8;
        logic [7:0]  v8 [16];
        int lat, lat2, nd;

        v8 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h0F, 8'h10, 8'h55,
               8'h7E, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hFE, 8'hFF};

        arst = 1'b1;
        s4 = 1'b0; a4 = '0; b4 = '0; m4 = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; m8 = 1'b0;
        #3;
        chk("rst_ready4", 64'(rdy4), 64'd1);
        chk("rst_done4", 64'(dn4), 64'd0);
        chk("rst_result4", 64'(res4), 64'd0);
        chk("rst_ready8", 64'(rdy8), 64'd1);
        chk("rst_result8", 64'(res8), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        tick();

        run4(4'h8, 4'h8, 1'b1, r4, lat);
        chk("neg8xneg8_lat", 64'(lat), 64'd4);
        chk("neg8xneg8", 64'(r4), 64'h40);
        tick();
        chk("done_one_cycle", 64'(dn4), 64'd0);
        chk("result_hold", 64'(res4), 64'h40);

        run4(4'hF, 4'hF, 1'b0, r4, lat);
        chk("u15x15", 64'(r4), 64'hE1);
        run4(4'hF, 4'hF, 1'b1, r4, lat);
        chk("sneg1xneg1", 64'(r4), 64'h01);

        a4 = 4'h7; b4 = 4'hF; m4 = 1'b1; s4 = 1'b1;
        tick();
        nd = 0; lat = -1; r4 = '0;
        for (int i = 1; i <= 8; i++) begin
            if (i <= 4) begin
                s4 = 1'b1; a4 = 4'(i); b4 = 4'h3; m4 = 1'b0;
            end else begin
                s4 = 1'b0;
            end
            tick();
            if (dn4) begin
                nd++;
                if (lat < 0) begin
                    lat = i;
                    r4 = res4;
                end
            end
        end
        chk("busy_ignore_ndone", 64'(nd), 64'd1);
        chk("busy_ignore_lat", 64'(lat), 64'd4);
        chk("busy_ignore_res", 64'(r4), 64'hF9);
        chk("busy_ignore_hold", 64'(res4), 64'hF9);

        run4(4'h1, 4'h1, 1'b0, r4, lat);
        chk("u1x1", 64'(r4), 64'h01);
        a4 = 4'h7; b4 = 4'hF; m4 = 1'b1; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (dn4) begin
                lat = i;
                break;
            end
        end
        chk("b2b_first_lat", 64'(lat), 64'd4);
        chk("b2b_first_res", 64'(res4), 64'hF9);
        a4 = 4'h3; b4 = 4'h5; m4 = 1'b0; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        chk("b2b_accepted", 64'(rdy4), 64'd0);
        chk("b2b_done_low", 64'(dn4), 64'd0);
        lat2 = -1;
        for (int j = 2; j <= 20; j++) begin
            tick();
            if (dn4) begin
                lat2 = j;
                break;
            end
            chk("b2b_hold", 64'(res4), 64'hF9);
        end
        chk("b2b_second_lat", 64'(lat2), 64'd5);
        chk("b2b_second_res", 64'(res4), 64'h0F);

        a4 = 4'h5; b4 = 4'h6; m4 = 1'b0; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        tick();
        arst = 1'b1;
        #1;
        chk("abort_result", 64'(res4), 64'h00);
        chk("abort_ready", 64'(rdy4), 64'd1);
        chk("abort_done", 64'(dn4), 64'd0);
        tick();
        arst = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dn4) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        run4(4'h2, 4'h3, 1'b1, r4, lat);
        chk("post_abort_lat", 64'(lat), 64'd4);
        chk("post_abort_2x3", 64'(r4), 64'h06);

        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run4(4'(x), 4'(y), bit'(m), r4, lat);
                    chk("sweep4_lat", 64'(lat), 64'd4);
                    chk("sweep4", 64'(r4),
                        ref_mul(4, 32'(x), 32'(y), bit'(m)));
                end
            end
        end

        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run8(v8[x], v8[y], bit'(m), r8, lat);
                    chk("sweep8_lat", 64'(lat), 64'd8);
                    chk("sweep8", 64'(r8),
                        ref_mul(8, 32'(v8[x]), 32'(v8[y]), bit'(m)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
